// File: rtl/branch_pc_unit_pkg.sv
// Shared encodings for the ID-stage branch/PC unit: instruction classes,
// operand-hazard classes and control FSM states.
package branch_pc_unit_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_J    = 3'b011;
  localparam logic [2:0] BR_JR   = 3'b100;

  localparam logic [1:0] HZ_NONE = 2'b00;
  localparam logic [1:0] HZ_ALU  = 2'b01;
  localparam logic [1:0] HZ_LOAD = 2'b10;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_WAIT2 = 2'b01;
  localparam logic [1:0] ST_WAIT1 = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // beq/bne/jr read register operands and so can be held back by a hazard.
  function automatic logic needs_operands(input logic [2:0] bt);
    return (bt == BR_BEQ) || (bt == BR_BNE) || (bt == BR_JR);
  endfunction

  function automatic logic is_taken(input logic [2:0] bt, input logic equal);
    return ((bt == BR_BEQ) && equal) || ((bt == BR_BNE) && !equal) ||
           (bt == BR_J) || (bt == BR_JR);
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control/target bus between the ID stage and the branch/PC unit.
interface branch_pc_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                equal;
  logic [2:0]          branch_type;
  logic [PC_WIDTH-1:0] branch_target;
  logic [25:0]         jump_target;
  logic [PC_WIDTH-1:0] jr_addr;
  logic [PC_WIDTH-1:0] ifid_pcplus4;
  logic [1:0]          operand_hazard;
  logic                stall_ext;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcplus4;
  logic                stall_ifid;
  logic                flush_ifid;
  logic [15:0]         taken_count;

  modport master (
    output equal, branch_type, branch_target, jump_target, jr_addr,
           ifid_pcplus4, operand_hazard, stall_ext,
    input  pc, pcplus4, stall_ifid, flush_ifid, taken_count
  );

  modport slave (
    input  equal, branch_type, branch_target, jump_target, jr_addr,
           ifid_pcplus4, operand_hazard, stall_ext,
    output pc, pcplus4, stall_ifid, flush_ifid, taken_count
  );
endinterface

// File: rtl/branch_pc_unit_next_pc_mux.sv
// Combinational next-PC selection for a resolving ID-stage instruction.
module next_pc_mux
  import branch_pc_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                taken,
  input  logic [2:0]          branch_type,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [25:0]         jump_target,
  input  logic [PC_WIDTH-1:0] jr_addr,
  input  logic [PC_WIDTH-1:0] ifid_pcplus4,
  input  logic [PC_WIDTH-1:0] pcplus4,
  output logic [PC_WIDTH-1:0] next_pc
);

  always_comb begin
    next_pc = pcplus4;
    if (taken) begin
      case (branch_type)
        BR_BEQ, BR_BNE: next_pc = branch_target;
        // j keeps the region bits of the delay-slot-free PC+4 of the jump itself
        BR_J:           next_pc = {ifid_pcplus4[PC_WIDTH-1:28], jump_target, 2'b00};
        BR_JR:          next_pc = jr_addr;
        default:        next_pc = pcplus4;
      endcase
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter owner: resolves ID-stage branches/jumps, inserts operand-hazard
// stalls ahead of resolution and squashes the wrong-path fetch on a redirect.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input logic              clk,
  input logic              rst,
  branch_pc_unit_if.slave  bus
);

  logic [1:0]          state, state_nxt;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pcplus4;
  logic [PC_WIDTH-1:0] next_pc;
  logic [15:0]         taken_count_q;
  logic                hazard;
  logic                resolve;
  logic                stall;
  logic                taken;
  logic                flush;

  assign pcplus4 = pc_q + PC_WIDTH'(4);
  assign hazard  = needs_operands(bus.branch_type) && (bus.operand_hazard != HZ_NONE);
  assign taken   = is_taken(bus.branch_type, bus.equal);
  assign flush   = resolve && taken;

  // External freeze outranks the FSM; reset forces both strobes low.
  always_comb begin
    resolve   = 1'b0;
    stall     = 1'b0;
    state_nxt = state;
    if (rst) begin
      state_nxt = ST_RUN;
    end else if (bus.stall_ext) begin
      stall = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard) begin
            stall     = 1'b1;
            state_nxt = (bus.operand_hazard == HZ_ALU) ? ST_WAIT1 : ST_WAIT2;
          end else begin
            resolve = 1'b1;
          end
        end
        ST_WAIT2: begin
          stall     = 1'b1;
          state_nxt = ST_WAIT1;
        end
        ST_WAIT1: begin
          resolve   = 1'b1;
          state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  next_pc_mux #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc_mux (
    .taken         (taken),
    .branch_type   (bus.branch_type),
    .branch_target (bus.branch_target),
    .jump_target   (bus.jump_target),
    .jr_addr       (bus.jr_addr),
    .ifid_pcplus4  (bus.ifid_pcplus4),
    .pcplus4       (pcplus4),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      pc_q          <= RESET_PC;
      taken_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (resolve) pc_q <= next_pc;
      if (flush) taken_count_q <= taken_count_q + 16'd1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pcplus4     = pcplus4;
  assign bus.stall_ifid  = stall;
  assign bus.flush_ifid  = flush;
  assign bus.taken_count = taken_count_q;

endmodule
